msp_frame_sched: RTL and testbench
==================================

# msp_frame_sched

Frame scheduler that sequences the mel-spectrogram datapath. It loads window coefficients, then streams one prime window and the following hop segments from the ICB→MSP sample FIFO into the MEL_SPEC core. It tracks mel-band outputs per frame, counts frames up to N_FRAMES, and reports completion and sticky error status to the ICB register layer. It drives the `win_coe_lut_en`, `start` and `signal_en` controls that the ICB_MSP top previously tied off.

## Interface
- `N_FRAMES`, 101: frames per utterance.
- `WIN_LEN`, 480: samples in the first frame; also the number of window coefficients.
- `HOP_LEN`, 160: new samples per subsequent frame.
- `MEL_BANDS`, 40: `mel_avail` strobes per frame.
- `CNT_W`, 16: width of internal counters; must hold max(WIN_LEN, N_FRAMES).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_load_win` in 1: pulse; request a window-coefficient load.
- `cfg_go` in 1: pulse; start an utterance.
- `cfg_abort` in 1: level/pulse; abandon the current operation.
- `err_clr` in 1: pulse; clear the sticky error flags.
- `in_fifo_empty` in 1: sample FIFO empty.
- `in_fifo_rd_en` out 1: sample FIFO read strobe. Combinational.
- `out_fifo_full` in 1: MSP→ICB result FIFO full.
- `mel_avail` in 1: one mel value produced by MEL_SPEC.
- `win_coe_lut_en` out 1: FIFO data this cycle is a window coefficient. Registered.
- `start` out 1: FIFO data this cycle is a signal sample. Registered.
- `signal_en` out 1: same timing as `start`; the MEL_SPEC input-valid.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse at utterance end.
- `win_loaded` out 1: a coefficient load has completed since reset.
- `frame_idx` out CNT_W: index of the frame in progress, 0..N_FRAMES-1.
- `err_nowin`, `err_ovf`, `err_unexp` out 1 each: sticky error flags.

## Operation
States: IDLE, WLOAD, PRIME, HOP, WAIT_MEL, DONE.

- **IDLE**
  - `cfg_load_win` → WLOAD with `remain`=WIN_LEN.
  - Else `cfg_go` with `win_loaded`=1 → PRIME with `remain`=WIN_LEN and `frame_idx`=0.
  - `cfg_go` with `win_loaded`=0 → set `err_nowin`; stay in IDLE.
  - If both are asserted in the same cycle, `cfg_load_win` wins and `cfg_go` is dropped.
- **Read rule**
  - `in_fifo_rd_en` = (state ∈ {WLOAD, PRIME, HOP}) & !`in_fifo_empty` & (`remain` ≠ 0).
  - Each read decrements `remain`.
  - When FIFO is empty, the block stalls silently. No timeout.
- **WLOAD**
  - On the read that takes `remain` from 1 to 0: set `win_loaded` and go to IDLE.
- **PRIME / HOP**
  - On the read that takes `remain` from 1 to 0: go to WAIT_MEL with `mel_cnt`=0.
- **WAIT_MEL**
  - Each `mel_avail` increments `mel_cnt`.
  - At the strobe that makes `mel_cnt`=MEL_BANDS:
    - If `frame_idx`=N_FRAMES-1 → DONE.
    - Else increment `frame_idx`, load `remain`=HOP_LEN, and go to HOP.
- **DONE**
  - Assert `done` for one cycle, then go to IDLE. `frame_idx` holds its final value until the next `cfg_go`.
- **Abort**
  - `cfg_abort` in any state → IDLE next cycle.
  - Clears `remain`, `mel_cnt` and `frame_idx`. No `done` pulse.
  - An abort during WLOAD leaves `win_loaded` at its previous value.
  - `cfg_abort` has priority over all other inputs.
- **Ignored inputs**
  - `cfg_go` and `cfg_load_win` are ignored when `busy`=1.
- **Errors** (sticky until `err_clr` or `rst`; a set in the same cycle as `err_clr` wins)
  - `err_ovf`: `mel_avail` & `out_fifo_full`. The strobe is still counted.
  - `err_unexp`: `mel_avail` in any state other than WAIT_MEL. The strobe is not counted.
- **Counters**
  - All counters are unsigned CNT_W.
  - `remain` never wraps because reads are gated by `remain` ≠ 0.

## Timing
- **Reset values**: state=IDLE. All outputs 0, including `frame_idx`, `win_loaded` and the error flags.
- **Data alignment**: FIFO read data is valid one cycle after `in_fifo_rd_en`. Therefore:
  - `start` = `signal_en` = registered (`in_fifo_rd_en` & state ∈ {PRIME, HOP}).
  - `win_coe_lut_en` = registered (`in_fifo_rd_en` & state = WLOAD).
  - Both assert exactly one cycle after the matching read.
- **Start latency**: `cfg_go` at cycle t → `busy`=1 at t+1. The first `in_fifo_rd_en` can occur at t+1.
- **Throughput**: one sample per cycle when the FIFO is non-empty.
- **Frame end**: after the last read of a frame, the state is WAIT_MEL on the next cycle. A `mel_avail` arriving in that same cycle is counted.
- **Completion**: the final `mel_avail` at cycle t → `done`=1 at t+1, `busy`=0 at t+2.
- **Abort**: `cfg_abort` at cycle t → `busy`=0 at t+1. `start` and `win_coe_lut_en` may still be high at t+1 for a read issued at t; that sample is not counted.

## Test plan
Use N_FRAMES=3, WIN_LEN=8, HOP_LEN=4, MEL_BANDS=2.

1. **Coefficient load**: `cfg_load_win` with FIFO always non-empty → 8 consecutive `in_fifo_rd_en`, `win_coe_lut_en` high for 8 cycles lagging by 1, then `win_loaded`=1 and `busy`=0.
2. **Full utterance**: `cfg_go`, bench returns 2 `mel_avail` per frame → 8+4+4=16 reads, `frame_idx` goes 0→1→2, `done` pulses once after the 6th `mel_avail`, no errors.
3. **Go without window**: `cfg_go` after reset with no load → `err_nowin`=1, `busy` stays 0, zero reads. `err_clr` → 0.
4. **Empty stalls**: toggle `in_fifo_empty` every other cycle during PRIME → exactly 8 reads total, `start` pulses only after actual reads, no error.
5. **Mid-frame abort**: `cfg_abort` after 5 reads of PRIME → IDLE next cycle, `frame_idx`=0. A following `cfg_go` reads a full 8 again.
6. **Error flags**:
   - `mel_avail` with `out_fifo_full`=1 in WAIT_MEL → `err_ovf`=1, frame still advances.
   - `mel_avail` in IDLE → `err_unexp`=1.
   - `err_clr` together with a new `mel_avail` in IDLE → `err_unexp` stays 1.

Source files
------------

// File: rtl/msp_frame_sched.sv
// ---------------------------------------------------------------------------
// msp_frame_sched
//
// Frame scheduler for the mel-spectrogram datapath. It first loads the window
// coefficients from the ICB->MSP sample FIFO. It then streams one prime
// window followed by hop segments into the MEL_SPEC core. It counts mel-band
// outputs per frame and frames per utterance, and reports completion and
// sticky error status to the register layer.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   cfg_load_win    : pulse, request a window-coefficient load
//   cfg_go          : pulse, start an utterance (needs win_loaded)
//   cfg_abort       : abandon current operation, highest priority
//   err_clr         : pulse, clear sticky error flags
//   in_fifo_empty   : sample FIFO empty
//   in_fifo_rd_en   : sample FIFO read strobe (combinational)
//   out_fifo_full   : result FIFO full
//   mel_avail       : one mel value produced by MEL_SPEC
//   win_coe_lut_en  : FIFO data this cycle is a window coefficient
//   start/signal_en : FIFO data this cycle is a signal sample
//   busy, done      : state != IDLE / one-cycle utterance-end pulse
//   win_loaded      : a coefficient load has completed since reset
//   frame_idx       : frame in progress, 0..N_FRAMES-1
//   err_nowin/err_ovf/err_unexp : sticky error flags
// ---------------------------------------------------------------------------
module msp_frame_sched #(
    parameter int N_FRAMES  = 101,
    parameter int WIN_LEN   = 480,
    parameter int HOP_LEN   = 160,
    parameter int MEL_BANDS = 40,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load_win,
    input  logic             cfg_go,
    input  logic             cfg_abort,
    input  logic             err_clr,
    input  logic             in_fifo_empty,
    output logic             in_fifo_rd_en,
    input  logic             out_fifo_full,
    input  logic             mel_avail,
    output logic             win_coe_lut_en,
    output logic             start,
    output logic             signal_en,
    output logic             busy,
    output logic             done,
    output logic             win_loaded,
    output logic [CNT_W-1:0] frame_idx,
    output logic             err_nowin,
    output logic             err_ovf,
    output logic             err_unexp
);

    typedef enum logic [2:0] {
        S_IDLE, S_WLOAD, S_PRIME, S_HOP, S_WAIT_MEL, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] WIN_LEN_C  = CNT_W'(WIN_LEN);
    localparam logic [CNT_W-1:0] HOP_LEN_C  = CNT_W'(HOP_LEN);
    localparam logic [CNT_W-1:0] MEL_LAST   = CNT_W'(MEL_BANDS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(N_FRAMES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] mel_cnt_q, mel_cnt_d;
    logic [CNT_W-1:0] frame_idx_q, frame_idx_d;
    logic             win_loaded_q, win_loaded_d;
    logic             win_coe_q, win_coe_d;
    logic             start_q, start_d;
    logic             err_nowin_q, err_nowin_d;
    logic             err_ovf_q, err_ovf_d;
    logic             err_unexp_q, err_unexp_d;
    logic             rd_state;
    logic             last_read;

    // Reads are gated by remain != 0, so remain can never wrap below zero.
    assign rd_state      = (state_q == S_WLOAD) || (state_q == S_PRIME) || (state_q == S_HOP);
    assign in_fifo_rd_en = rd_state && !in_fifo_empty && (remain_q != '0);
    assign last_read     = in_fifo_rd_en && (remain_q == ONE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d      = state_q;
        remain_d     = remain_q;
        mel_cnt_d    = mel_cnt_q;
        frame_idx_d  = frame_idx_q;
        win_loaded_d = win_loaded_q;

        // Read data arrives one cycle after the strobe, so the qualifiers
        // are registered copies of the read decision.
        win_coe_d = in_fifo_rd_en && (state_q == S_WLOAD);
        start_d   = in_fifo_rd_en && ((state_q == S_PRIME) || (state_q == S_HOP));

        // Sticky flags: clear first, then any set this cycle overrides it.
        err_nowin_d = err_clr ? 1'b0 : err_nowin_q;
        err_ovf_d   = err_clr ? 1'b0 : err_ovf_q;
        err_unexp_d = err_clr ? 1'b0 : err_unexp_q;
        if (mel_avail && out_fifo_full)     err_ovf_d   = 1'b1;
        if (mel_avail && state_q != S_WAIT_MEL) err_unexp_d = 1'b1;

        if (in_fifo_rd_en) remain_d = remain_q - ONE;

        if (cfg_abort) begin
            state_d     = S_IDLE;
            remain_d    = '0;
            mel_cnt_d   = '0;
            frame_idx_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cfg_load_win) begin
                        state_d  = S_WLOAD;
                        remain_d = WIN_LEN_C;
                    end else if (cfg_go) begin
                        if (win_loaded_q) begin
                            state_d     = S_PRIME;
                            remain_d    = WIN_LEN_C;
                            frame_idx_d = '0;
                        end else begin
                            err_nowin_d = 1'b1;
                        end
                    end
                end
                S_WLOAD: begin
                    if (last_read) begin
                        win_loaded_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
                S_PRIME, S_HOP: begin
                    if (last_read) begin
                        state_d   = S_WAIT_MEL;
                        mel_cnt_d = '0;
                    end
                end
                S_WAIT_MEL: begin
                    if (mel_avail) begin
                        mel_cnt_d = mel_cnt_q + ONE;
                        if (mel_cnt_q == MEL_LAST) begin
                            if (frame_idx_q == FRAME_LAST) begin
                                state_d = S_DONE;
                            end else begin
                                frame_idx_d = frame_idx_q + ONE;
                                remain_d    = HOP_LEN_C;
                                state_d     = S_HOP;
                            end
                        end
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            remain_q     <= '0;
            mel_cnt_q    <= '0;
            frame_idx_q  <= '0;
            win_loaded_q <= 1'b0;
            win_coe_q    <= 1'b0;
            start_q      <= 1'b0;
            err_nowin_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            err_unexp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remain_q     <= remain_d;
            mel_cnt_q    <= mel_cnt_d;
            frame_idx_q  <= frame_idx_d;
            win_loaded_q <= win_loaded_d;
            win_coe_q    <= win_coe_d;
            start_q      <= start_d;
            err_nowin_q  <= err_nowin_d;
            err_ovf_q    <= err_ovf_d;
            err_unexp_q  <= err_unexp_d;
        end
    end

    assign win_coe_lut_en = win_coe_q;
    assign start          = start_q;
    assign signal_en      = start_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign win_loaded     = win_loaded_q;
    assign frame_idx      = frame_idx_q;
    assign err_nowin      = err_nowin_q;
    assign err_ovf        = err_ovf_q;
    assign err_unexp      = err_unexp_q;

endmodule

// File: tb/tb_msp_frame_sched.sv
// ---------------------------------------------------------------------------
// tb_msp_frame_sched
//
// Self-checking bench for msp_frame_sched with N_FRAMES=3, WIN_LEN=8,
// HOP_LEN=4, MEL_BANDS=2. A negedge monitor pushes the expected qualifier
// kind for every FIFO read and pops it when the qualifier is due one cycle
// later. Scenario tasks drive stimulus and check control/status outputs.
// ---------------------------------------------------------------------------
module tb_msp_frame_sched;

    localparam int CNT_W = 16;

    typedef enum logic {K_SIG, K_WIN} kind_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_load_win, cfg_go, cfg_abort, err_clr;
    logic             in_fifo_empty, out_fifo_full, mel_avail;
    logic             in_fifo_rd_en, win_coe_lut_en, start, signal_en;
    logic             busy, done, win_loaded;
    logic [CNT_W-1:0] frame_idx;
    logic             err_nowin, err_ovf, err_unexp;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_sig    = 0;
    int    n_win    = 0;
    kind_t exp_kind = K_SIG;
    logic [1:0] exp_q[$];

    msp_frame_sched #(
        .N_FRAMES(3), .WIN_LEN(8), .HOP_LEN(4), .MEL_BANDS(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_load_win(cfg_load_win), .cfg_go(cfg_go), .cfg_abort(cfg_abort),
        .err_clr(err_clr), .in_fifo_empty(in_fifo_empty),
        .in_fifo_rd_en(in_fifo_rd_en), .out_fifo_full(out_fifo_full),
        .mel_avail(mel_avail), .win_coe_lut_en(win_coe_lut_en),
        .start(start), .signal_en(signal_en), .busy(busy), .done(done),
        .win_loaded(win_loaded), .frame_idx(frame_idx),
        .err_nowin(err_nowin), .err_ovf(err_ovf), .err_unexp(err_unexp)
    );

    always #5 clk = ~clk;

    // Scoreboard: each read expects exactly one qualifier strobe next cycle.
    always @(negedge clk) begin
        logic [1:0] exp;
        if (!rst) begin
            n_checks++;
            if (signal_en !== start) begin
                n_fail++;
                $display("FAIL signal_en_eq_start: got %b required %b", signal_en, start);
            end
            exp = 2'b00;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            n_checks++;
            if ({win_coe_lut_en, start} !== exp) begin
                n_fail++;
                $display("FAIL qualifier {win,start} at %0t: got %b required %b",
                         $time, {win_coe_lut_en, start}, exp);
            end
            if (start === 1'b1)          n_sig++;
            if (win_coe_lut_en === 1'b1) n_win++;
            if (in_fifo_rd_en === 1'b1)
                exp_q.push_back({exp_kind == K_WIN, exp_kind == K_SIG});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts reads until n are seen or the budget expires; optional
    // empty toggling every cycle.
    task automatic run_reads(input int n, input bit toggle, input string tag);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 200) begin
            if (toggle) in_fifo_empty = cyc[0];
            @(negedge clk);
            if (in_fifo_rd_en === 1'b1) got++;
            if (toggle && in_fifo_empty) begin
                n_checks++;
                if (in_fifo_rd_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s rd_while_empty: got %b required 0", tag, in_fifo_rd_en);
                end
            end
            tick();
            cyc++;
        end
        in_fifo_empty = 1'b0;
        n_checks++;
        if (got != n) begin
            n_fail++;
            $display("FAIL %s read_count: got %0d required %0d", tag, got, n);
        end
    endtask

    task automatic pulse_abort();
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_load_win = 0; cfg_go = 0; cfg_abort = 0; err_clr = 0;
        in_fifo_empty = 0; out_fifo_full = 0; mel_avail = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_fifo_rd_en, win_coe_lut_en, start, signal_en, busy, done, win_loaded,
             err_nowin, err_ovf, err_unexp} !== 10'b0 || frame_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b frame_idx=%0d required all zero",
                     {in_fifo_rd_en, win_coe_lut_en, start, signal_en, busy, done,
                      win_loaded, err_nowin, err_ovf, err_unexp}, frame_idx);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_go_nowin();
        int reads = 0;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || err_nowin !== 1'b1) begin
            n_fail++;
            $display("FAIL nowin_flag: got busy=%b err_nowin=%b required busy=0 err_nowin=1",
                     busy, err_nowin);
        end
        repeat (4) begin
            @(negedge clk);
            if (in_fifo_rd_en === 1'b1) reads++;
        end
        n_checks++;
        if (reads != 0) begin
            n_fail++;
            $display("FAIL nowin_reads: got %0d required 0", reads);
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_nowin !== 1'b0) begin
            n_fail++;
            $display("FAIL nowin_clear: got %b required 0", err_nowin);
        end
    endtask

    task automatic test_load();
        int win0 = n_win;
        exp_kind = K_WIN;
        cfg_load_win = 1'b1;
        tick();
        cfg_load_win = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_fifo_rd_en !== 1'b1 || busy !== 1'b1 || win_loaded !== 1'b0) begin
                n_fail++;
                $display("FAIL load_cycle%0d: got rd=%b busy=%b win_loaded=%b required 1 1 0",
                         i, in_fifo_rd_en, busy, win_loaded);
            end
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (in_fifo_rd_en !== 1'b0 || busy !== 1'b0 || win_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL load_end: got rd=%b busy=%b win_loaded=%b required 0 0 1",
                     in_fifo_rd_en, busy, win_loaded);
        end
        tick();
        n_checks++;
        if (n_win - win0 != 8) begin
            n_fail++;
            $display("FAIL load_win_strobes: got %0d required 8", n_win - win0);
        end
        exp_kind = K_SIG;
    endtask

    task automatic test_utterance();
        int sig0 = n_sig;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL utt_busy: got %b required 1", busy);
        end
        for (int f = 0; f < 3; f++) begin
            run_reads((f == 0) ? 8 : 4, 1'b0, "utt");
            @(negedge clk);
            n_checks++;
            if (frame_idx !== CNT_W'(f) || in_fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL utt_frame%0d: got idx=%0d rd=%b busy=%b required idx=%0d rd=0 busy=1",
                         f, frame_idx, in_fifo_rd_en, busy, f);
            end
            mel_avail = 1'b1;
            tick();
            tick();
            mel_avail = 1'b0;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL utt_done_pulse: got done=%b busy=%b required 1 1", done, busy);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || frame_idx !== CNT_W'(2) ||
            {err_nowin, err_ovf, err_unexp} !== 3'b000) begin
            n_fail++;
            $display("FAIL utt_end: got done=%b busy=%b idx=%0d errs=%b required 0 0 2 000",
                     done, busy, frame_idx, {err_nowin, err_ovf, err_unexp});
        end
        tick();
        n_checks++;
        if (n_sig - sig0 != 16) begin
            n_fail++;
            $display("FAIL utt_sample_strobes: got %0d required 16", n_sig - sig0);
        end
    endtask

    task automatic test_stalls();
        int sig0 = n_sig;
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        run_reads(8, 1'b1, "stall");
        @(negedge clk);
        n_checks++;
        if (in_fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_wait_mel: got rd=%b busy=%b required 0 1", in_fifo_rd_en, busy);
        end
        tick();
        pulse_abort();
        tick();
        n_checks++;
        if (n_sig - sig0 != 8 || {err_nowin, err_ovf, err_unexp} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_totals: got strobes=%0d errs=%b required 8 000",
                     n_sig - sig0, {err_nowin, err_ovf, err_unexp});
        end
    endtask

    task automatic test_abort();
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        run_reads(5, 1'b0, "abort_pre");
        pulse_abort();
        n_checks++;
        if (busy !== 1'b0 || frame_idx !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b idx=%0d done=%b required 0 0 0",
                     busy, frame_idx, done);
        end
        @(negedge clk);
        n_checks++;
        if (in_fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_read: got %b required 0", in_fifo_rd_en);
        end
        tick();
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        run_reads(8, 1'b0, "abort_restart");
        @(negedge clk);
        n_checks++;
        if (in_fifo_rd_en !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_restart_full: got rd=%b busy=%b required 0 1", in_fifo_rd_en, busy);
        end
        tick();
        pulse_abort();
    endtask

    task automatic test_both_cfg();
        int win0 = n_win;
        int sig0 = n_sig;
        exp_kind = K_WIN;
        cfg_go = 1'b1;
        cfg_load_win = 1'b1;
        tick();
        cfg_go = 1'b0;
        cfg_load_win = 1'b0;
        run_reads(8, 1'b0, "both");
        tick();
        n_checks++;
        if (busy !== 1'b0 || n_win - win0 != 8 || n_sig - sig0 != 0) begin
            n_fail++;
            $display("FAIL both_load_wins: got busy=%b win=%0d sig=%0d required 0 8 0",
                     busy, n_win - win0, n_sig - sig0);
        end
        exp_kind = K_SIG;
    endtask

    task automatic test_errors();
        cfg_go = 1'b1;
        tick();
        cfg_go = 1'b0;
        run_reads(8, 1'b0, "err");
        out_fifo_full = 1'b1;
        mel_avail = 1'b1;
        tick();
        out_fifo_full = 1'b0;
        tick();
        mel_avail = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b1 || err_unexp !== 1'b0 || frame_idx !== CNT_W'(1) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_advance: got ovf=%b unexp=%b idx=%0d busy=%b required 1 0 1 1",
                     err_ovf, err_unexp, frame_idx, busy);
        end
        pulse_abort();
        n_checks++;
        if (frame_idx !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_clears_idx: got idx=%0d busy=%b required 0 0", frame_idx, busy);
        end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b required 0", err_ovf);
        end
        mel_avail = 1'b1;
        tick();
        mel_avail = 1'b0;
        n_checks++;
        if (err_unexp !== 1'b1 || err_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_idle: got unexp=%b ovf=%b required 1 0", err_unexp, err_ovf);
        end
        err_clr = 1'b1;
        mel_avail = 1'b1;
        tick();
        err_clr = 1'b0;
        mel_avail = 1'b0;
        n_checks++;
        if (err_unexp !== 1'b1) begin
            n_fail++;
            $display("FAIL unexp_set_beats_clr: got %b required 1", err_unexp);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if (err_unexp !== 1'b0) begin
            n_fail++;
            $display("FAIL unexp_clear: got %b required 0", err_unexp);
        end
    endtask

    initial begin
        test_reset();
        test_go_nowin();
        test_load();
        test_utterance();
        test_stalls();
        test_abort();
        test_both_cfg();
        test_errors();
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
